// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller: merges per-stage stall requests into a monotonic
// stall bus, accepts EX redirects, and drains a wrong-path fetch after a redirect.
module pipeline_ctrl #(
    parameter int unsigned COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_if,
    input  logic               stallreq_id,
    input  logic               stallreq_ex,
    input  logic               stallreq_mem,
    input  logic               branch_flag,
    input  logic [31:0]        branch_target,
    output logic [6:0]         stall,
    output logic               flush,
    output logic               new_pc_valid,
    output logic [31:0]        new_pc,
    output logic               drop_fetch,
    output logic [COUNT_W-1:0] stall_cycles,
    output logic [COUNT_W-1:0] flush_count
);

    localparam int unsigned STALL_W = 7;
    localparam int unsigned ADDR_W  = 32;

    localparam logic [STALL_W-1:0] STALL_MEM  = 7'b0111111;
    localparam logic [STALL_W-1:0] STALL_EX   = 7'b0011111;
    localparam logic [STALL_W-1:0] STALL_ID   = 7'b0001111;
    localparam logic [STALL_W-1:0] STALL_IF   = 7'b0000111;
    localparam logic [STALL_W-1:0] STALL_NONE = 7'b0000000;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t state;
    state_t state_next;
    logic   accept;

    // Priority encode the requests; deeper stages freeze everything upstream.
    always_comb begin
        stall = STALL_NONE;
        if (rst) begin
            stall = STALL_NONE;
        end else if (stallreq_mem) begin
            stall = STALL_MEM;
        end else if (stallreq_ex) begin
            stall = STALL_EX;
        end else if (stallreq_id) begin
            stall = STALL_ID;
        end else if (stallreq_if) begin
            stall = STALL_IF;
        end
    end

    // EX holds branch_flag while EX/MEM is frozen, so accept exactly once when it frees.
    assign accept = branch_flag && !stall[4] && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        flush        = 1'b0;
        new_pc_valid = 1'b0;
        new_pc       = ADDR_W'(0);
        drop_fetch   = 1'b0;

        if (accept) begin
            flush        = 1'b1;
            new_pc_valid = 1'b1;
            new_pc       = branch_target;
        end

        unique case (state)
            RUN: begin
                // A redirect racing an in-flight fetch leaves a stale response to discard.
                if (accept && stallreq_if) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                drop_fetch = !rst;
                if (!stallreq_if) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Free-running performance counters; wrap naturally on overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= COUNT_W'(0);
            flush_count  <= COUNT_W'(0);
        end else begin
            if (stall != STALL_NONE) begin
                stall_cycles <= stall_cycles + COUNT_W'(1);
            end
            if (accept) begin
                flush_count <= flush_count + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a driver applies directed vectors and queues
// hand-computed expectations; a monitor samples on the falling edge and compares.
module tb_pipeline_ctrl;

    localparam int unsigned COUNT_W = 32;

    logic               clk;
    logic               rst;
    logic               stallreq_if;
    logic               stallreq_id;
    logic               stallreq_ex;
    logic               stallreq_mem;
    logic               branch_flag;
    logic [31:0]        branch_target;
    logic [6:0]         stall;
    logic               flush;
    logic               new_pc_valid;
    logic [31:0]        new_pc;
    logic               drop_fetch;
    logic [COUNT_W-1:0] stall_cycles;
    logic [COUNT_W-1:0] flush_count;

    pipeline_ctrl #(.COUNT_W(COUNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .branch_flag  (branch_flag),
        .branch_target(branch_target),
        .stall        (stall),
        .flush        (flush),
        .new_pc_valid (new_pc_valid),
        .new_pc       (new_pc),
        .drop_fetch   (drop_fetch),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [6:0]  stall;
        logic        flush;
        logic        npv;
        logic [31:0] pc;
        logic        drop;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   driver_done = 1'b0;

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s vec %0d: got 0x%08h expected 0x%08h", name, idx, act, req);
        end
    endtask

    // Monitor: outputs are combinational, so sample mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("stall",        e.idx, 32'(stall),        32'(e.stall));
            check("flush",        e.idx, 32'(flush),        32'(e.flush));
            check("new_pc_valid", e.idx, 32'(new_pc_valid), 32'(e.npv));
            check("new_pc",       e.idx, new_pc,            e.pc);
            check("drop_fetch",   e.idx, 32'(drop_fetch),   32'(e.drop));
            check("stall_cycles", e.idx, 32'(stall_cycles), e.sc);
            check("flush_count",  e.idx, 32'(flush_count),  e.fc);
        end
    end

    int vec_n = 0;

    // Drive one cycle's inputs just after the rising edge and queue its expectation.
    task automatic vec(input logic r, input logic m, input logic x, input logic d,
                       input logic f, input logic b, input logic [31:0] tgt,
                       input logic [6:0] e_stall, input logic e_flush, input logic e_npv,
                       input logic [31:0] e_pc, input logic e_drop,
                       input logic [31:0] e_sc, input logic [31:0] e_fc);
        exp_t e;
        @(posedge clk);
        #1;
        rst           = r;
        stallreq_mem  = m;
        stallreq_ex   = x;
        stallreq_id   = d;
        stallreq_if   = f;
        branch_flag   = b;
        branch_target = tgt;
        e.idx   = vec_n;
        e.stall = e_stall;
        e.flush = e_flush;
        e.npv   = e_npv;
        e.pc    = e_pc;
        e.drop  = e_drop;
        e.sc    = e_sc;
        e.fc    = e_fc;
        exp_q.push_back(e);
        vec_n++;
    endtask

    initial begin
        rst = 1'b1; stallreq_mem = 1'b0; stallreq_ex = 1'b0; stallreq_id = 1'b0;
        stallreq_if = 1'b0; branch_flag = 1'b0; branch_target = 32'h0;
        repeat (2) @(posedge clk);

        //   rst m  x  d  f  br target         stall  fl npv pc            drop sc  fc
        vec(1, 1, 0, 0, 1, 1, 32'h0000_0040, 7'h00, 0, 0, 32'h0,        0,  0,  0);
        vec(0, 0, 0, 0, 0, 0, 32'h0,         7'h00, 0, 0, 32'h0,        0,  0,  0);
        vec(0, 0, 0, 0, 1, 0, 32'h0,         7'h07, 0, 0, 32'h0,        0,  0,  0);
        vec(0, 0, 0, 1, 0, 0, 32'h0,         7'h0F, 0, 0, 32'h0,        0,  1,  0);
        vec(0, 0, 1, 0, 0, 0, 32'h0,         7'h1F, 0, 0, 32'h0,        0,  2,  0);
        vec(0, 1, 0, 0, 0, 0, 32'h0,         7'h3F, 0, 0, 32'h0,        0,  3,  0);
        vec(0, 1, 0, 0, 1, 0, 32'h0,         7'h3F, 0, 0, 32'h0,        0,  4,  0);
        vec(0, 0, 0, 0, 0, 0, 32'h0,         7'h00, 0, 0, 32'h0,        0,  5,  0);
        // plain redirect
        vec(0, 0, 0, 0, 0, 1, 32'h0000_0100, 7'h00, 1, 1, 32'h100,      0,  5,  0);
        vec(0, 0, 0, 0, 0, 0, 32'h0,         7'h00, 0, 0, 32'h0,        0,  5,  1);
        // branch held off by MEM for two cycles
        vec(0, 1, 0, 0, 0, 1, 32'h0000_0180, 7'h3F, 0, 0, 32'h0,        0,  5,  1);
        vec(0, 1, 0, 0, 0, 1, 32'h0000_0180, 7'h3F, 0, 0, 32'h0,        0,  6,  1);
        vec(0, 0, 0, 0, 0, 1, 32'h0000_0180, 7'h00, 1, 1, 32'h180,      0,  7,  1);
        vec(0, 0, 0, 0, 0, 0, 32'h0,         7'h00, 0, 0, 32'h0,        0,  7,  2);
        // held off by EX, then accepted alongside an ID load-use stall
        vec(0, 0, 1, 0, 0, 1, 32'h0000_01C0, 7'h1F, 0, 0, 32'h0,        0,  7,  2);
        vec(0, 0, 0, 1, 0, 1, 32'h0000_01C0, 7'h0F, 1, 1, 32'h1C0,      0,  8,  2);
        // redirect with fetch in flight, second redirect during DRAIN
        vec(0, 0, 0, 0, 1, 1, 32'h0000_0300, 7'h07, 1, 1, 32'h300,      0,  9,  3);
        vec(0, 0, 0, 0, 1, 0, 32'h0,         7'h07, 0, 0, 32'h0,        1, 10,  4);
        vec(0, 0, 0, 0, 1, 1, 32'h0000_0200, 7'h07, 1, 1, 32'h200,      1, 11,  4);
        vec(0, 0, 0, 0, 1, 0, 32'h0,         7'h07, 0, 0, 32'h0,        1, 12,  5);
        vec(0, 0, 0, 0, 0, 0, 32'h0,         7'h00, 0, 0, 32'h0,        1, 13,  5);
        vec(0, 0, 0, 0, 0, 0, 32'h0,         7'h00, 0, 0, 32'h0,        0, 13,  5);
        // enter DRAIN again, then reset while MEM stalls
        vec(0, 0, 0, 0, 1, 1, 32'h0000_0400, 7'h07, 1, 1, 32'h400,      0, 13,  5);
        vec(0, 1, 0, 0, 1, 1, 32'h0000_0500, 7'h3F, 0, 0, 32'h0,        1, 14,  6);
        vec(1, 1, 0, 0, 1, 1, 32'h0000_0500, 7'h00, 0, 0, 32'h0,        0, 15,  6);
        vec(0, 1, 0, 0, 1, 0, 32'h0,         7'h3F, 0, 0, 32'h0,        0,  0,  0);
        vec(0, 0, 0, 0, 0, 0, 32'h0,         7'h00, 0, 0, 32'h0,        0,  1,  0);
        driver_done = 1'b1;
    end

    // Wait for the monitor to drain the scoreboard, bounded by a cycle budget.
    initial begin
        int budget;
        budget = 0;
        while (!(driver_done && exp_q.size() == 0) && budget < 1000) begin
            @(posedge clk);
            budget++;
        end
        if (budget >= 1000) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d expectations left, expected 0", exp_q.size());
        end
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the RV32I pipeline. It merges stall requests from IF, ID, EX and MEM into the monotonic stall bus that every pipeline register consumes, and accepts taken-branch redirects from EX. A redirect that collides with an outstanding instruction fetch triggers a drain state machine so the stale fetch response is discarded. Two performance counters report stall cycles and accepted redirects.

## Interface
- COUNT_W, 32, width of both performance counters
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- stallreq_if  input  1  IF waiting on instruction memory (level)
- stallreq_id  input  1  ID load-use hazard (level)
- stallreq_ex  input  1  EX multi-cycle operation (level)
- stallreq_mem  input  1  MEM waiting on data memory (level)
- branch_flag  input  1  EX requests redirect; held high by EX while stall[4]=1
- branch_target  input  32  redirect address
- stall  output  7 (`StallBus)  bit k=1 holds stage k: [0] PC, [1] IF, [2] IF/ID, [3] ID/EX, [4] EX/MEM, [5] MEM/WB, [6] WB
- flush  output  1  clears IF/ID and ID/EX to bubble this cycle
- new_pc_valid  output  1  PC loads new_pc this cycle, overriding stall[0]
- new_pc  output  32  redirect address
- drop_fetch  output  1  IF must discard the response it delivers this cycle
- stall_cycles  output  COUNT_W  cycles with stall≠0
- flush_count  output  COUNT_W  accepted redirects

## Operation
- Stall encoding, combinational, highest priority wins:
  - stallreq_mem: 7'b0111111
  - stallreq_ex: 7'b0011111
  - stallreq_id: 7'b0001111
  - stallreq_if: 7'b0000111
  - none: 7'b0000000
- Invariant: stall is monotonic, i.e. if stall[k]=1 then stall[j]=1 for all j<k. A register whose bit k=1 and bit k+1=0 loads a bubble.
- Branch acceptance: accept = branch_flag && !stall[4]. In the accept cycle: flush=1, new_pc_valid=1, new_pc=branch_target. Otherwise flush=0, new_pc_valid=0, new_pc=0.
- FSM states: RUN, DRAIN.
  - RUN → DRAIN when accept && stallreq_if (a fetch of the wrong-path PC is in flight).
  - DRAIN → RUN on the edge after a cycle where stallreq_if=0 (stale response delivered and dropped).
  - accept in DRAIN: redirect is taken (new PC issued), state stays DRAIN.
- drop_fetch = (state==DRAIN). The accept cycle needs no drop_fetch because flush already clears IF/ID.
- stall_cycles increments by 1 on each clock with stall≠0. flush_count increments by 1 on each accept. Both wrap modulo 2^COUNT_W and never saturate.

## Timing
- Reset (rst high at an edge): state=RUN, stall_cycles=0, flush_count=0. While rst is high: stall=0, flush=0, new_pc_valid=0, new_pc=0, drop_fetch=0, regardless of the request inputs.
- Reset mid-DRAIN returns to RUN immediately. drop_fetch is 0 in the first cycle after reset.
- stall, flush, new_pc_valid and new_pc are combinational from the current inputs and state, with zero-cycle latency. Only the FSM state and the counters are registered.
- Counters update at the edge ending the qualifying cycle and are visible the following cycle.
- A branch held off by stallreq_mem or stallreq_ex produces no flush. It is accepted in the first cycle those requests drop, and flush_count increments exactly once.
- Simultaneous branch_flag and stallreq_id: accepted, since stall[4]=0. flush overrides the ID/EX bubble, so both paths give a bubble.
- Simultaneous branch_flag and stallreq_if=1: accepted, and DRAIN is entered at the next edge.

## Test plan
- Single-cycle requests: assert each of stallreq_if/id/ex/mem alone, then mem+if together → stall = 0x07/0x0F/0x1F/0x3F, then 0x3F. stall_cycles advances 5 over 5 cycles.
- branch_flag=1, branch_target=0x0000_0100, no stalls → same cycle flush=1, new_pc_valid=1, new_pc=0x100. Next cycle flush_count=1 and state stays RUN.
- branch_flag held 3 cycles with stallreq_mem high for the first 2 → flush/new_pc_valid only in cycle 3, and flush_count=1.
- branch accepted while stallreq_if high, stallreq_if drops 4 cycles later → drop_fetch high for the 4 cycles after accept, including the cycle stallreq_if=0, then low.
- Second branch (target 0x200) during DRAIN → new_pc=0x200 that cycle, flush_count=2, and DRAIN persists until stallreq_if falls.
- rst asserted mid-DRAIN with stallreq_mem high → stall=0 and drop_fetch=0 during reset, and counters read 0 after reset.
